// File: rtl/led_pwm_fader_pkg.sv
// rtl/led_pwm_fader_pkg.sv - shared state encodings and default parameters for the LED fader
package led_pwm_fader_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RISING  = 2'd1,
        ST_ON      = 2'd2,
        ST_FALLING = 2'd3
    } chan_state_e;

    localparam int DEF_N_LED    = 4;
    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_FADE_DIV = 48_828;

    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_fade_chan.sv
// rtl/led_fade_chan.sv - one LED channel: fade FSM, brightness level and registered PWM compare
module led_fade_chan
    import led_pwm_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                tick,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                ramping
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    chan_state_e         state, state_n;
    logic [PWM_BITS-1:0] level, level_n;

    // The request decides the direction first, so a reversal coinciding with a
    // tick already steps toward the new target; state then follows the new level.
    always_comb begin
        level_n = level;
        state_n = state;
        if (!enable) begin
            level_n = req ? MAX : '0;
        end else if (tick) begin
            if (req && level != MAX) begin
                level_n = level + PWM_BITS'(1);
            end else if (!req && level != '0) begin
                level_n = level - PWM_BITS'(1);
            end
        end
        if (req) begin
            state_n = (level_n == MAX) ? ST_ON : ST_RISING;
        end else begin
            state_n = (level_n == '0) ? ST_OFF : ST_FALLING;
        end
    end

    assign ramping = (state == ST_RISING) || (state == ST_FALLING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            level <= '0;
            led   <= 1'b0;
        end else begin
            state <= state_n;
            level <= level_n;
            // Full brightness forced high so the wrap of pwm_cnt never blips the LED off.
            led   <= (level == MAX) || (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - fades each sequencer LED in/out with per-channel PWM brightness ramps
module led_pwm_fader
    import led_pwm_fader_pkg::*;
#(
    parameter int N_LED    = DEF_N_LED,
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int FADE_DIV = DEF_FADE_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_LED-1:0] led_in,
    input  logic             enable,
    output logic [N_LED-1:0] led_out,
    output logic             busy
);

    localparam int             DIV_W    = div_width(FADE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [N_LED-1:0]    led_q;
    logic [N_LED-1:0]    ramping;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            div_cnt <= '0;
            led_q   <= '0;
            busy    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            led_q   <= led_in;
            busy    <= |ramping;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_chan
        led_fade_chan #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .req     (led_q[i]),
            .tick    (tick),
            .enable  (enable),
            .pwm_cnt (pwm_cnt),
            .led     (led_out[i]),
            .ramping (ramping[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - directed self-checking bench for led_pwm_fader (FADE_DIV=4, PWM_BITS=8)
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] led_in = 4'h0;
    logic [3:0] led_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    led_pwm_fader #(
        .N_LED    (4),
        .PWM_BITS (8),
        .FADE_DIV (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led_in  (led_in),
        .enable  (enable),
        .led_out (led_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic release_reset(input logic [3:0] pat);
        @(negedge clk);
        rst    = 1'b1;
        led_in = pat;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (busy !== val && n < bound);
    endtask

    task automatic count_high(input int ch, input int win, output int h);
        h = 0;
        repeat (win) begin
            @(negedge clk);
            h += int'(led_out[ch]);
        end
    endtask

    task automatic count_bad(input logic [3:0] want, input int win, output int bad);
        bad = 0;
        repeat (win) begin
            @(negedge clk);
            if (led_out !== want || busy !== 1'b0) bad++;
        end
    endtask

    function automatic int in_range(input int v, input int lo, input int hi, input int nominal);
        return (v >= lo && v <= hi) ? nominal : v;
    endfunction

    int n, n2, h, bad;

    initial begin
        // 1: reset holds everything quiet, release starts all four rising
        led_in = 4'hF;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (led_out !== 4'h0 || busy !== 1'b0) bad++;
        end
        check("reset_quiet", bad, 0);
        rst = 1'b0;
        wait_busy(1'b1, 8, n);
        check("reset_release_busy", n, 3);
        wait_busy(1'b0, 1100, n2);
        check("all_ramp_len", in_range(n + n2, 1016, 1028, 1021), 1021);
        count_bad(4'hF, 0, bad);
        bad = 0;
        repeat (64) begin
            @(negedge clk);
            if (led_out !== 4'hF) bad++;
        end
        check("all_on_const", bad, 0);

        // 2: fade in from idle
        release_reset(4'h0);
        repeat (10) @(negedge clk);
        led_in = 4'b0001;
        wait_busy(1'b1, 8, n);
        check("fade_busy_rise", n, 3);
        wait_busy(1'b0, 1100, n2);
        check("fade_ramp_len", in_range(n + n2, 1016, 1028, 1021), 1021);
        count_high(0, 256, h);
        check("fade_full_on", h, 256);
        check("fade_others_off", led_out[3:1], 0);

        // 3: duty at level 64 (tick frozen right after the 64th step)
        release_reset(4'b0001);
        repeat (256) @(posedge clk);
        #1 force dut.tick = 1'b0;
        repeat (2) @(negedge clk);
        count_high(0, 256, h);
        check("duty_64", h, 64);
        check("duty_busy", busy, 1);
        release dut.tick;

        // 4: reversal at level 100 holds the level, then falls the rest of the way
        release_reset(4'b0001);
        repeat (400) @(posedge clk);
        #1;
        led_in = 4'b0000;
        force dut.tick = 1'b0;
        repeat (4) @(negedge clk);
        count_high(0, 256, h);
        check("reverse_hold_100", h, 100);
        check("reverse_busy", busy, 1);
        @(negedge clk);
        release dut.tick;
        wait_busy(1'b0, 600, n);
        check("reverse_fall_len", in_range(n, 394, 406, 400), 400);
        count_high(0, 256, h);
        check("reverse_off", h, 0);

        // 5: snap mode
        @(negedge clk);
        enable = 1'b0;
        led_in = 4'b1000;
        repeat (3) @(negedge clk);
        count_bad(4'b1000, 256, bad);
        check("snap_ch3", bad, 0);
        led_in = 4'b0100;
        repeat (3) @(negedge clk);
        count_bad(4'b0100, 256, bad);
        check("snap_ch2", bad, 0);

        // 6: reset mid-ramp at level 150
        enable = 1'b1;
        release_reset(4'b0001);
        repeat (600) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset_led", led_out, 0);
        check("midreset_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_busy(1'b1, 8, n);
        wait_busy(1'b0, 1100, n2);
        check("midreset_restart_len", in_range(n + n2, 1016, 1028, 1021), 1021);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
